// File: rtl/dvp_frame_tx_if.sv
// Pixel FIFO read port and DVP camera bus of the frame transmitter.
// master = transmitter, slave = FIFO/sink side.
interface dvp_frame_tx_if;
  logic [15:0] pix_data;
  logic        pix_empty;
  logic        pix_rd_en;
  logic        dvp_pclk;
  logic        dvp_href;
  logic        dvp_vsync;
  logic [7:0]  dvp_data;

  modport master (
    input  pix_data, pix_empty,
    output pix_rd_en, dvp_pclk, dvp_href, dvp_vsync, dvp_data
  );

  modport slave (
    output pix_data, pix_empty,
    input  pix_rd_en, dvp_pclk, dvp_href, dvp_vsync, dvp_data
  );
endinterface

// File: rtl/dvp_frame_tx.sv
// OV5640-style DVP transmitter: serialises RGB565 pixels from a FWFT FIFO
// into vsync/href/8-bit data frames, high byte first, at pclk = clk_50m/2.
module dvp_frame_tx #(
  parameter int H_ACTIVE = 480,
  parameter int H_BLANK  = 64,
  parameter int V_SYNC   = 4,
  parameter int V_BACK   = 8,
  parameter int V_ACTIVE = 272,
  parameter int V_FRONT  = 8
) (
  input  logic           clk_50m,
  input  logic           sys_rst,
  input  logic           tx_en,
  dvp_frame_tx_if.master bus,
  output logic           frame_done,
  output logic           busy,
  output logic           underflow
);

  localparam int LINE     = 2 * H_ACTIVE + H_BLANK;
  localparam int H_W      = ($clog2(LINE) > 12) ? $clog2(LINE) : 12;
  localparam int V_MAX_SB = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int V_MAX_AF = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int V_MAX    = (V_MAX_SB > V_MAX_AF) ? V_MAX_SB : V_MAX_AF;
  localparam int V_W      = ($clog2(V_MAX + 1) > 11) ? $clog2(V_MAX + 1) : 11;

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT
  } state_t;

  function automatic int lines_of(state_t s);
    case (s)
      S_VSYNC:  return V_SYNC;
      S_VBACK:  return V_BACK;
      S_ACTIVE: return V_ACTIVE;
      S_VFRONT: return V_FRONT;
      default:  return 0;
    endcase
  endfunction

  // Frame order; S_IDLE after S_VFRONT marks the end of the frame.
  function automatic state_t succ(state_t s);
    case (s)
      S_VSYNC:  return S_VBACK;
      S_VBACK:  return S_ACTIVE;
      S_ACTIVE: return S_VFRONT;
      default:  return S_IDLE;
    endcase
  endfunction

  // Zero-line phases are skipped entirely.
  function automatic state_t skip_from(state_t s);
    state_t r = s;
    for (int i = 0; i < 4; i++)
      if (r != S_IDLE && lines_of(r) == 0) r = succ(r);
    return r;
  endfunction

  logic           ph;
  state_t         state, nxt_state;
  logic [H_W-1:0] h_cnt, nxt_h;
  logic [V_W-1:0] v_cnt, nxt_v;
  logic [15:0]    pix_reg;
  logic           end_frame;
  logic           in_href;

  assign bus.dvp_pclk = ph;

  // Position the transmitter moves to on the next tick.
  always_comb begin
    // NOTE: every variable gets a default first so no branch infers a latch.
    nxt_state = state;
    nxt_h     = h_cnt;
    nxt_v     = v_cnt;
    end_frame = 1'b0;
    if (state == S_IDLE) begin
      nxt_h = '0;
      nxt_v = '0;
      if (tx_en) nxt_state = skip_from(S_VSYNC);
    end else if (int'(h_cnt) == LINE - 1) begin
      nxt_h = '0;
      if (int'(v_cnt) == lines_of(state) - 1) begin
        nxt_v     = '0;
        nxt_state = skip_from(succ(state));
        if (nxt_state == S_IDLE) begin
          end_frame = 1'b1;
          nxt_state = tx_en ? skip_from(S_VSYNC) : S_IDLE;
        end
      end else begin
        nxt_v = v_cnt + 1'b1;
      end
    end else begin
      nxt_h = h_cnt + 1'b1;
    end
    in_href = (nxt_state == S_ACTIVE) && (int'(nxt_h) < 2 * H_ACTIVE);
  end

  always_ff @(posedge clk_50m or posedge sys_rst) begin
    if (sys_rst) begin
      ph            <= 1'b0;
      state         <= S_IDLE;
      h_cnt         <= '0;
      v_cnt         <= '0;
      pix_reg       <= '0;
      bus.dvp_href  <= 1'b0;
      bus.dvp_vsync <= 1'b0;
      bus.dvp_data  <= 8'h00;
      bus.pix_rd_en <= 1'b0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      ph            <= ~ph;
      bus.pix_rd_en <= 1'b0;
      frame_done    <= 1'b0;
      if (ph) begin
        state         <= nxt_state;
        h_cnt         <= nxt_h;
        v_cnt         <= nxt_v;
        busy          <= (nxt_state != S_IDLE);
        bus.dvp_vsync <= (nxt_state == S_VSYNC);
        bus.dvp_href  <= in_href;
        frame_done    <= end_frame;
        if (!in_href) begin
          bus.dvp_data <= 8'h00;
        end else if (!nxt_h[0]) begin
          // High byte goes out straight from the FIFO head; a missing pixel
          // is sent as black and flagged.
          if (bus.pix_empty) begin
            bus.dvp_data <= 8'h00;
            pix_reg      <= 16'h0000;
            underflow    <= 1'b1;
          end else begin
            bus.dvp_data  <= bus.pix_data[15:8];
            pix_reg       <= bus.pix_data;
            bus.pix_rd_en <= 1'b1;
          end
        end else begin
          bus.dvp_data <= pix_reg[7:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_dvp_frame_tx.sv
// Bench for dvp_frame_tx: a frame-position reference model checks every clock,
// plus a table of fixed expectations for the first frame and directed corners.
module tb_dvp_frame_tx;
  localparam int H_ACTIVE = 4, H_BLANK = 4, V_SYNC = 1, V_BACK = 1;
  localparam int V_ACTIVE = 2, V_FRONT = 1;
  localparam int LINE  = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME = LINE * (V_SYNC + V_BACK + V_ACTIVE + V_FRONT);

  logic clk = 1'b0;
  logic sys_rst;
  logic tx_en;
  logic frame_done, busy, underflow;

  dvp_frame_tx_if bus ();

  dvp_frame_tx #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_SYNC(V_SYNC),
    .V_BACK(V_BACK), .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT)
  ) dut (
    .clk_50m(clk), .sys_rst(sys_rst), .tx_en(tx_en), .bus(bus),
    .frame_done(frame_done), .busy(busy), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc_now = 0, fd_cnt = 0;
  int g_slot = 0, hole_slot = -1;
  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // FWFT FIFO: pop on a seen strobe, optionally hide the head for one slot.
  always @(negedge clk) begin
    if (bus.pix_rd_en === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
    bus.pix_data  = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0000;
    bus.pix_empty = (fifo_q.size() == 0) || (g_slot == hole_slot);
  end

  // Reference model: position inside the frame in pclk periods.
  int          m_pos;
  bit          m_ph;
  logic [15:0] m_word;
  logic        e_pclk, e_href, e_vsync, e_rd, e_fd, e_busy, e_uf;
  logic [7:0]  e_data;

  task automatic model_reset();
    m_pos = -1; m_ph = 1'b0; m_word = 16'h0;
    e_pclk = 0; e_href = 0; e_vsync = 0; e_rd = 0; e_fd = 0; e_busy = 0; e_uf = 0;
    e_data = 8'h00;
  endtask

  task automatic model_step(input logic en);
    bit tick;
    int line, col;
    tick   = m_ph;
    m_ph   = ~m_ph;
    e_pclk = m_ph;
    e_rd   = 1'b0;
    e_fd   = 1'b0;
    if (!tick) return;
    if (m_pos < 0) begin
      if (en) m_pos = 0;
    end else begin
      m_pos++;
      if (m_pos == FRAME) begin
        e_fd  = 1'b1;
        m_pos = en ? 0 : -1;
      end
    end
    e_busy = (m_pos >= 0);
    e_vsync = 1'b0; e_href = 1'b0; e_data = 8'h00;
    if (m_pos >= 0) begin
      line    = m_pos / LINE;
      col     = m_pos % LINE;
      e_vsync = (line < V_SYNC);
      e_href  = (line >= V_SYNC + V_BACK) && (line < V_SYNC + V_BACK + V_ACTIVE) &&
                (col < 2 * H_ACTIVE);
      if (e_href) begin
        if (col % 2 == 0) begin
          if (g_slot == hole_slot || exp_q.size() == 0) begin
            m_word = 16'h0000;
            e_uf   = 1'b1;
          end else begin
            m_word = exp_q.pop_front();
            e_rd   = 1'b1;
          end
          g_slot++;
          e_data = m_word[15:8];
        end else begin
          e_data = m_word[7:0];
        end
      end
    end
  endtask

  always @(posedge clk) begin
    cyc_now++;
    if (sys_rst) model_reset();
    else         model_step(tx_en);
    #1;
    if (frame_done === 1'b1) fd_cnt++;
    check("pclk", bus.dvp_pclk, e_pclk);
    check("vsync", bus.dvp_vsync, e_vsync);
    check("href", bus.dvp_href, e_href);
    check("data", bus.dvp_data, e_data);
    check("rd_en", bus.pix_rd_en, e_rd);
    check("frame_done", frame_done, e_fd);
    check("busy", busy, e_busy);
    check("underflow", underflow, e_uf);
  end

  task automatic wait_vsync_rise(input int budget, output int at, output bit ok);
    logic prev;
    int n;
    prev = bus.dvp_vsync; ok = 1'b0; at = 0; n = 0;
    while (n < budget && !ok) begin
      @(posedge clk); #1; n++;
      if (bus.dvp_vsync === 1'b1 && prev === 1'b0) begin ok = 1'b1; at = cyc_now; end
      prev = bus.dvp_vsync;
    end
  endtask

  task automatic wait_frame_done(input int budget, output int at, output bit ok);
    int n;
    ok = 1'b0; at = 0; n = 0;
    while (n < budget && !ok) begin
      @(posedge clk); #1; n++;
      if (frame_done === 1'b1) begin ok = 1'b1; at = cyc_now; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n;
    ok = 1'b0; n = 0;
    while (n < budget && !ok) begin
      @(posedge clk); #1; n++;
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  // Fixed expectations for frame 1, offsets in clk after the vsync rise.
  typedef struct packed {
    int         off;
    logic       vs;
    logic       hr;
    logic [7:0] d;
    logic       rd;
    logic       fd;
    logic       bz;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int at1, at2, atf, cur, fd_before;
    bit ok;

    vecs.push_back(vec_t'{0,   1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{23,  1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{24,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{47,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{48,  1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{49,  1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{50,  1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{52,  1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{54,  1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{62,  1'b0, 1'b1, 8'h08, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{64,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{71,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{72,  1'b0, 1'b1, 8'h09, 1'b1, 1'b0, 1'b1});
    vecs.push_back(vec_t'{86,  1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{88,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{119, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{120, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1});
    vecs.push_back(vec_t'{121, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});

    sys_rst = 1'b1; tx_en = 1'b0;
    bus.pix_data = 16'h0000; bus.pix_empty = 1'b1;
    for (int i = 0; i < 8; i++) push_word({8'(2 * i + 1), 8'(2 * i + 2)});
    for (int i = 0; i < 16; i++) push_word(16'($urandom));

    // Reset state, then start with tx_en already high.
    repeat (3) @(posedge clk);
    #2;
    check("rst_vsync", bus.dvp_vsync, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", bus.dvp_data, 8'h00);
    @(negedge clk);
    sys_rst = 1'b0; tx_en = 1'b1;
    wait_vsync_rise(10, at1, ok);
    check("start_vsync_seen", ok, 1'b1);
    check("start_latency_clk", at1 - (cyc_now - 2), 2);

    cur = 0;
    foreach (vecs[i]) begin
      while (cur < vecs[i].off) begin @(posedge clk); #1; cur++; end
      check($sformatf("vec%0d_vsync", vecs[i].off), bus.dvp_vsync, vecs[i].vs);
      check($sformatf("vec%0d_href", vecs[i].off), bus.dvp_href, vecs[i].hr);
      check($sformatf("vec%0d_data", vecs[i].off), bus.dvp_data, vecs[i].d);
      check($sformatf("vec%0d_rd_en", vecs[i].off), bus.pix_rd_en, vecs[i].rd);
      check($sformatf("vec%0d_frame_done", vecs[i].off), frame_done, vecs[i].fd);
      check($sformatf("vec%0d_busy", vecs[i].off), busy, vecs[i].bz);
    end

    // Frame 3 follows back to back; drop tx_en in the middle of its line 1.
    wait_vsync_rise(200, at2, ok);
    check("frame3_vsync_seen", ok, 1'b1);
    check("frame3_period", at2 - at1, 2 * 2 * FRAME);
    repeat (56) @(posedge clk);
    @(negedge clk);
    tx_en = 1'b0;
    wait_frame_done(200, atf, ok);
    check("frame3_done_seen", ok, 1'b1);
    check("frame3_done_time", atf - at2, 2 * FRAME);
    repeat (2) @(negedge clk);
    check("three_frame_dones", fd_cnt, 3);
    check("idle_busy", busy, 1'b0);
    wait_vsync_rise(150, at1, ok);
    check("no_restart", ok, 1'b0);

    // Third pixel of the next frame is missing from the FIFO.
    hole_slot = g_slot + 2;
    for (int i = 0; i < 8; i++) push_word(16'($urandom) | 16'h8080);
    repeat (2) @(negedge clk);
    check("uf_before", underflow, 1'b0);
    tx_en = 1'b1;
    wait_vsync_rise(8, at1, ok);
    check("hole_vsync_seen", ok, 1'b1);
    @(negedge clk);
    tx_en = 1'b0;
    wait_frame_done(200, atf, ok);
    check("hole_done_seen", ok, 1'b1);
    check("uf_set", underflow, 1'b1);
    repeat (20) @(negedge clk);
    check("uf_sticky", underflow, 1'b1);
    hole_slot = -1;

    // Reset in the middle of active line 1, then a clean restart.
    for (int i = 0; i < 16; i++) push_word(16'($urandom));
    repeat (2) @(negedge clk);
    tx_en = 1'b1;
    wait_vsync_rise(8, at1, ok);
    check("rst_frame_vsync_seen", ok, 1'b1);
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("pre_reset_href", bus.dvp_href, 1'b1);
    fd_before = fd_cnt;
    sys_rst = 1'b1;
    #1;
    check("mid_rst_href", bus.dvp_href, 1'b0);
    check("mid_rst_vsync", bus.dvp_vsync, 1'b0);
    check("mid_rst_data", bus.dvp_data, 8'h00);
    check("mid_rst_rd_en", bus.pix_rd_en, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_uf", underflow, 1'b0);
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;
    wait_vsync_rise(8, at1, ok);
    check("restart_vsync_seen", ok, 1'b1);
    check("no_done_on_abort", fd_cnt, fd_before);
    @(negedge clk);
    tx_en = 1'b0;
    wait_frame_done(200, atf, ok);
    check("restart_done_time", atf - at1, 2 * FRAME);

    // Random data, holes, run lengths and tx_en drop points.
    for (int it = 0; it < 6; it++) begin
      int frames;
      frames = $urandom_range(1, 2);
      for (int i = 0; i < 8 * frames; i++) push_word(16'($urandom));
      hole_slot = ($urandom_range(0, 1) == 1) ? g_slot + $urandom_range(0, 8 * frames - 1) : -1;
      repeat ($urandom_range(2, 7)) @(negedge clk);
      fd_before = fd_cnt;
      tx_en = 1'b1;
      wait_vsync_rise(8, at1, ok);
      check("rand_vsync_seen", ok, 1'b1);
      if (frames == 2) repeat ($urandom_range(130, 230)) @(posedge clk);
      else             repeat ($urandom_range(1, 110)) @(posedge clk);
      @(negedge clk);
      tx_en = 1'b0;
      wait_idle(400, ok);
      check("rand_idle_seen", ok, 1'b1);
      repeat (2) @(negedge clk);
      check("rand_frame_count", fd_cnt - fd_before, frames);
    end
    hole_slot = -1;

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dvp_frame_tx.md
Name: dvp_frame_tx

Overview:
- OV5640-style DVP sensor emulator. It drives pclk/href/vsync/8-bit data exactly as the camera does, sourcing RGB565 pixels from an upstream FWFT FIFO.
- It is the transmit counterpart of the camera capture path (8-bit DVP → 16-bit pixel). Use cases: loopback bench for the capture chain; second video source on the board.
- Emits high byte first, then low byte, per pixel. Frame: vsync pulse, back porch, active lines, front porch.

Parameters:
H_ACTIVE, 480, pixels per active line
H_BLANK, 64, href-low pclk periods per line
V_SYNC, 4, lines with vsync high
V_BACK, 8, blank lines after vsync
V_ACTIVE, 272, active lines per frame
V_FRONT, 8, blank lines before next vsync

Ports:
clk_50m  in  1  system clock; all logic on rising edge
sys_rst  in  1  asynchronous, active-high reset
tx_en  in  1  start/continue frame generation; sampled only at frame boundary
pix_data  in  16  FWFT FIFO head, RGB565
pix_empty  in  1  FIFO empty
pix_rd_en  out  1  one-clk FIFO pop strobe
dvp_pclk  out  1  pixel clock = clk_50m/2
dvp_href  out  1  line valid, active high
dvp_vsync  out  1  frame sync, active high
dvp_data  out  8  byte bus
frame_done  out  1  one-clk pulse at end of each frame
busy  out  1  high while a frame is in progress
underflow  out  1  sticky: a pixel was needed while pix_empty=1

Behaviour:
- Reset (async, all outputs): ph=0, dvp_pclk=0, href=0, vsync=0, data=8'h00, pix_rd_en=0, frame_done=0, busy=0, underflow=0, state=IDLE, counters=0.
- ph toggles every clk; dvp_pclk=ph.
- "Tick" = a clk edge with ph==1 (pclk falling). All state/counter/output updates occur only on ticks. Sinks sample on pclk rising.
- LINE = 2*H_ACTIVE + H_BLANK pclk periods.
  - h_cnt counts 0..LINE-1 and wraps.
  - v_cnt counts lines within the current state.
  - Counters are at least 12 bits (h) and 11 bits (v).
- FSM states: IDLE → VSYNC → VBACK → ACTIVE → VFRONT.
  - IDLE: on a tick with tx_en=1, go to VSYNC; set vsync=1 and busy=1 at that same edge. Latency from reset release with tx_en=1 is 2 clk.
  - Each non-IDLE state lasts its line count (V_SYNC/V_BACK/V_ACTIVE/V_FRONT), advancing when h_cnt wraps.
  - vsync=1 only in VSYNC. A parameter value of 0 skips that state.
  - VFRONT end: pulse frame_done for one clk on the tick edge. Then:
    - tx_en=1 → VSYNC directly, no idle gap.
    - tx_en=0 → IDLE, busy=0.
  - tx_en falling mid-frame has no effect until the frame completes.
- ACTIVE state:
  - href=1 for h_cnt 0..2*H_ACTIVE-1; 0 otherwise. href changes only on ticks.
  - Even h_cnt: dvp_data = pix_data[15:8] presented at that tick. pix_data is latched into pix_reg and pix_rd_en=1 for exactly that clk.
  - Odd h_cnt: dvp_data = pix_reg[7:0].
  - Underflow: if pix_empty=1 at an even-h_cnt tick, pix_rd_en stays 0, the pixel is sent as 16'h0000, and underflow sets (cleared only by reset).
  - Exactly H_ACTIVE pops per active line; V_ACTIVE*H_ACTIVE pops per frame.
- Outside active href: dvp_data=8'h00 and pix_rd_en=0.
- pix_rd_en is never asserted on non-tick cycles.
- Reset mid-frame: all outputs return to reset values immediately. No partial-frame completion and no frame_done.

Test Plan (H_ACTIVE=4, H_BLANK=4, V_SYNC=1, V_BACK=1, V_ACTIVE=2, V_FRONT=1; LINE=12 pclk, frame=60 pclk=120 clk):
- Reset release, tx_en=1, FIFO preloaded 16'h0102..16'h0F10 → vsync high 12 pclk; href rises 24 pclk after vsync rise; bytes 01,02,03,04,05,06,07,08 on line 1, then 09..10 on line 2; 8 pix_rd_en pulses; frame_done exactly 120 clk after vsync rise.
- Pixel period → dvp_pclk period 2 clk; each href-high window 8 pclk, then 4 pclk low; href/data stable on every pclk rising edge.
- tx_en held 1 for 3 frames → vsync rises every 120 clk; no gap; frame_done ×3; busy stays 1.
- tx_en dropped at mid-line 1 → frame completes all 8 pixels; then IDLE, busy=0, no further vsync.
- pix_empty=1 for pixel 3 only → bytes 00,00 for that pixel; no pop that tick; underflow=1 and stays set; later pixels resume correctly.
- sys_rst asserted during ACTIVE → href/vsync/data/pix_rd_en/busy go to 0 within the same clk; no frame_done; restart produces a full-length clean frame.
